hash_sequencer: RTL and testbench

- Sequences one message hash: pad → sha256 → digest drain through the CAN-side fifo.
- Owns the shared single-port RAM bus:
  - drives RAM control (chipSel/wriEn/outEn);
  - selects which master drives addr/data;
  - starts/monitors pad and sha256;
  - controls fifo reset/wr/rd.
- Replaces ad-hoc bench sequencing; sits between the CAN frame builder and the hash datapath.

---
 rtl/hash_pkg.sv | 25 ++
 rtl/hash_sequencer_edge_det.sv | 24 ++
 rtl/hash_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_hash_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared state, bus-owner and error encodings for the hash sequencer
package hash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAD   = 3'd1,
    ST_SHA   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PAD  = 2'd1;
  localparam logic [1:0] OWN_SHA  = 2'd2;
  localparam logic [1:0] OWN_FIFO = 2'd3;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_WDOG = 2'd3;

  localparam int HASH_MAX_LEN      = 55;
  localparam int HASH_DIGEST_BYTES = 32;

endpackage

// File: rtl/hash_sequencer_edge_det.sv
// rtl/hash_sequencer_edge_det.sv - registered rising-edge detector for one handshake level
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic in_q, in_d;

  // next copy of the level is simply the current level
  always_comb begin
    in_d = sig_in;
  end

  // one-cycle delayed copy of the level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 1'b0;
    else        in_q <= in_d;
  end

  assign rise = sig_in & ~in_q;

endmodule

// File: rtl/hash_sequencer.sv
// rtl/hash_sequencer.sv - pad/sha256/drain sequencer owning the shared RAM bus; HASH_SEQ_WDOG_EN adds a watchdog
module hash_sequencer import hash_pkg::*; #(
  parameter int ADDR_W       = 10,
  parameter int LEN_W        = 8,
  parameter int MAX_LEN      = HASH_MAX_LEN,
  parameter int BLOCK_ADDR   = 0,
  parameter int DIGEST_ADDR  = 64,
  parameter int DIGEST_BYTES = HASH_DIGEST_BYTES,
  parameter int CYC_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [LEN_W-1:0]  msgLen,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [CYC_W-1:0]  cycles,
  output logic [LEN_W-1:0]  dataLen,
  output logic              padStart,
  input  logic              padFinish,
  output logic              shaStart,
  input  logic              shaFinish,
  input  logic              readPhase,
  input  logic              writePhase,
  output logic [ADDR_W-1:0] addrToBlock,
  output logic [ADDR_W-1:0] addrToDigest,
  output logic [1:0]        busOwner,
  output logic              chipSel,
  output logic              wriEn,
  output logic              outEn,
  output logic              fifoReset,
  output logic              fifoWr,
  output logic              fifoRd,
  input  logic              fifoEmpty,
  input  logic              fifoFull
);

  localparam int CNT_W = $clog2(DIGEST_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DIGEST_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [1:0]         err_q, err_d, bus_owner_q, bus_owner_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic [LEN_W-1:0]   data_len_q, data_len_d;
  logic               pad_start_q, pad_start_d, sha_start_q, sha_start_d;
  logic               chip_sel_q, chip_sel_d, wri_en_q, wri_en_d, out_en_q, out_en_d;
  logic               fifo_reset_q, fifo_reset_d, fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_next;
  logic               finish;
  logic [1:0]         finish_err;
  logic               pad_rise, sha_rise, read_rise, write_rise;

  edge_det u_pad_edge   (.clk(clk), .rst_n(rst), .sig_in(padFinish),  .rise(pad_rise));
  edge_det u_sha_edge   (.clk(clk), .rst_n(rst), .sig_in(shaFinish),  .rise(sha_rise));
  edge_det u_read_edge  (.clk(clk), .rst_n(rst), .sig_in(readPhase),  .rise(read_rise));
  edge_det u_write_edge (.clk(clk), .rst_n(rst), .sig_in(writePhase), .rise(write_rise));

`ifdef HASH_SEQ_WDOG_EN
  logic [7:0] pre_q, pre_d, wd_q, wd_d;
  logic       wd_expire;
  assign wd_expire = (state_q == ST_PAD || state_q == ST_SHA || state_q == ST_DRAIN) &&
                     (pre_q == 8'hFF) && (wd_q == 8'hFF);
`endif

  assign cnt_next = cnt_q + {{(CNT_W-1){1'b0}}, fifo_rd_q};

  // next-state and next-output computation; every output is a registered copy
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = ERR_OK;
    cycles_d     = cycles_q;
    data_len_d   = data_len_q;
    pad_start_d  = pad_start_q;
    sha_start_d  = sha_start_q;
    bus_owner_d  = bus_owner_q;
    chip_sel_d   = chip_sel_q;
    wri_en_d     = wri_en_q;
    out_en_d     = out_en_q;
    fifo_reset_d = fifo_reset_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_rd_d    = fifo_rd_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    finish       = 1'b0;
    finish_err   = ovf_q ? ERR_OVF : ERR_OK;

    if (busy_q && cycles_q != '1) cycles_d = cycles_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        fifo_reset_d = 1'b1;
        if (req) begin
          if (msgLen != '0 && msgLen <= MAX_LEN_V) begin
            data_len_d  = msgLen;
            cycles_d    = '0;
            busy_d      = 1'b1;
            ovf_d       = 1'b0;
            pad_start_d = 1'b1;
            bus_owner_d = OWN_PAD;
            chip_sel_d  = 1'b1;
            wri_en_d    = 1'b1;
            out_en_d    = 1'b0;
            state_d     = ST_PAD;
          end else begin
            done_d = 1'b1;
            err_d  = ERR_LEN;
          end
        end
      end
      ST_PAD: begin
        if (pad_rise) begin
          pad_start_d  = 1'b0;
          sha_start_d  = 1'b1;
          bus_owner_d  = OWN_SHA;
          fifo_reset_d = 1'b0;
          state_d      = ST_SHA;
        end
      end
      ST_SHA: begin
        // overflow is only remembered; sha256 keeps running
        if (fifoFull && fifo_wr_q) ovf_d = 1'b1;
        if (sha_rise) begin
          sha_start_d = 1'b0;
          fifo_wr_d   = 1'b0;
          wri_en_d    = 1'b0;
          out_en_d    = 1'b0;
          chip_sel_d  = 1'b0;
          cnt_d       = '0;
          bus_owner_d = OWN_FIFO;
          state_d     = ST_DRAIN;
        end else if (write_rise) begin
          out_en_d  = 1'b0;
          wri_en_d  = 1'b1;
          fifo_wr_d = 1'b1;
        end else if (read_rise) begin
          out_en_d  = 1'b1;
          wri_en_d  = 1'b0;
          fifo_wr_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_next;
        if (cnt_next == CNT_FULL || (fifoEmpty && cnt_next != '0)) finish = 1'b1;
        else fifo_rd_d = ~fifoEmpty;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef HASH_SEQ_WDOG_EN
    if (wd_expire) begin
      finish     = 1'b1;
      finish_err = ERR_WDOG;
    end
`endif

    if (finish) begin
      done_d       = 1'b1;
      err_d        = finish_err;
      busy_d       = 1'b0;
      bus_owner_d  = OWN_NONE;
      pad_start_d  = 1'b0;
      sha_start_d  = 1'b0;
      chip_sel_d   = 1'b0;
      wri_en_d     = 1'b0;
      out_en_d     = 1'b0;
      fifo_wr_d    = 1'b0;
      fifo_rd_d    = 1'b0;
      fifo_reset_d = 1'b1;
      state_d      = ST_DONE;
    end
  end

  // sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_OK;
      cycles_q     <= '0;
      data_len_q   <= '0;
      pad_start_q  <= 1'b0;
      sha_start_q  <= 1'b0;
      bus_owner_q  <= OWN_NONE;
      chip_sel_q   <= 1'b0;
      wri_en_q     <= 1'b0;
      out_en_q     <= 1'b0;
      fifo_reset_q <= 1'b1;
      fifo_wr_q    <= 1'b0;
      fifo_rd_q    <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cycles_q     <= cycles_d;
      data_len_q   <= data_len_d;
      pad_start_q  <= pad_start_d;
      sha_start_q  <= sha_start_d;
      bus_owner_q  <= bus_owner_d;
      chip_sel_q   <= chip_sel_d;
      wri_en_q     <= wri_en_d;
      out_en_q     <= out_en_d;
      fifo_reset_q <= fifo_reset_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef HASH_SEQ_WDOG_EN
  // 8-bit prescaler feeding an 8-bit count; both restart on every state entry
  always_comb begin
    pre_d = pre_q + 8'd1;
    wd_d  = (pre_q == 8'hFF) ? wd_q + 8'd1 : wd_q;
    if (state_d != state_q) begin
      pre_d = 8'd0;
      wd_d  = 8'd0;
    end
  end

  // watchdog counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q <= 8'd0;
      wd_q  <= 8'd0;
    end else begin
      pre_q <= pre_d;
      wd_q  <= wd_d;
    end
  end
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cycles       = cycles_q;
  assign dataLen      = data_len_q;
  assign padStart     = pad_start_q;
  assign shaStart     = sha_start_q;
  assign busOwner     = bus_owner_q;
  assign chipSel      = chip_sel_q;
  assign wriEn        = wri_en_q;
  assign outEn        = out_en_q;
  assign fifoReset    = fifo_reset_q;
  assign fifoWr       = fifo_wr_q;
  assign fifoRd       = fifo_rd_q;
  assign addrToBlock  = ADDR_W'(BLOCK_ADDR);
  assign addrToDigest = ADDR_W'(DIGEST_ADDR);

endmodule

// File: tb/tb_hash_sequencer.sv
// tb/tb_hash_sequencer.sv - self-checking bench for hash_sequencer (HASH_SEQ_WDOG_EN aware)
module tb_hash_sequencer;

  localparam int DIGEST = 32;

  logic        clk = 1'b0;
  logic        rst, req, padFinish, shaFinish, readPhase, writePhase, fifoEmpty, fifoFull;
  logic [7:0]  msgLen;
  logic        busy, done, padStart, shaStart, chipSel, wriEn, outEn, fifoReset, fifoWr, fifoRd;
  logic [1:0]  err, busOwner;
  logic [15:0] cycles;
  logic [7:0]  dataLen;
  logic [9:0]  addrToBlock, addrToDigest;

  int n_cmp = 0, n_bad = 0;
  int level = 0;
  int busy_cnt, rd_cnt, done_cnt, n_own, excl_bad = 0;
  logic [1:0]  last_err, last_own;
  logic [15:0] last_cycles;
  logic [7:0]  owners;
  bit          pad_seen;

  always #5 clk = ~clk;

  hash_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .msgLen(msgLen), .busy(busy), .done(done), .err(err),
    .cycles(cycles), .dataLen(dataLen), .padStart(padStart), .padFinish(padFinish),
    .shaStart(shaStart), .shaFinish(shaFinish), .readPhase(readPhase), .writePhase(writePhase),
    .addrToBlock(addrToBlock), .addrToDigest(addrToDigest), .busOwner(busOwner),
    .chipSel(chipSel), .wriEn(wriEn), .outEn(outEn), .fifoReset(fifoReset), .fifoWr(fifoWr),
    .fifoRd(fifoRd), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: behavioural fifo level update at the edge, then observation at the falling edge
  task automatic tick();
    logic rd_now, fr_now;
    rd_now = fifoRd;
    fr_now = fifoReset;
    @(posedge clk);
    if (fr_now) level = 0;
    else if (rd_now && level > 0) level--;
    @(negedge clk);
    fifoEmpty = (level == 0);
    if (busy) busy_cnt++;
    if (fifoRd) rd_cnt++;
    if (padStart) pad_seen = 1'b1;
    if (wriEn && outEn) excl_bad++;
    if (done) begin
      done_cnt++;
      last_err    = err;
      last_cycles = cycles;
    end
    if (busOwner !== last_own) begin
      owners   = {owners[5:0], busOwner};
      n_own++;
      last_own = busOwner;
    end
  endtask

  task automatic clear_obs();
    busy_cnt = 0; rd_cnt = 0; done_cnt = 0; n_own = 0; owners = 8'h0; last_own = busOwner;
  endtask

  // full hash transaction; expectations come from the protocol rules, not DUT internals
  task automatic run_hash(input int len, input int pd, input int tog, input int pre,
                          input bit inj, input bit again, input bit both);
    clear_obs();
    msgLen = 8'(len); req = 1'b1; tick(); req = 1'b0;
    check("busy_on_accept", busy, 1);
    check("data_len", dataLen, len);
    for (int i = 0; i < pd; i++) begin
      if (again && i == 0) begin msgLen = 8'd5; req = 1'b1; end
      tick();
      req = 1'b0;
    end
    padFinish = 1'b1;
    for (int i = 0; i < 8 && !shaStart; i++) tick();
    check("sha_start", {shaStart, padStart}, 2'b10);
    padFinish = 1'b0;
    for (int k = 0; k < tog; k++) begin
      readPhase = 1'b1; tick();
      check("read_phase_en", {wriEn, outEn}, 2'b01);
      readPhase = 1'b0; writePhase = 1'b1; tick();
      check("write_phase_en", {wriEn, outEn, fifoWr}, 3'b101);
      if (inj && k == 0) begin fifoFull = 1'b1; tick(); fifoFull = 1'b0; end
      writePhase = 1'b0; tick();
    end
    if (both) begin
      readPhase = 1'b1; writePhase = 1'b1; tick();
      check("both_rise", {wriEn, outEn}, 2'b10);
      readPhase = 1'b0; writePhase = 1'b0; tick();
    end
    level = pre; fifoEmpty = (pre == 0);
    shaFinish = 1'b1;
    for (int i = 0; i < 200 && done_cnt == 0; i++) tick();
    shaFinish = 1'b0;
    check("done_seen", done_cnt, 1);
    check("done_err", last_err, inj ? 2 : 0);
    check("drain_reads", rd_cnt, DIGEST);
    check("cycles", last_cycles, busy_cnt);
    check("owner_seq", {n_own[3:0], owners}, {4'd4, 2'd1, 2'd2, 2'd3, 2'd0});
    for (int i = 0; i < 4; i++) tick();
    check("done_single", done_cnt, 1);
    check("idle_after", {busy, busOwner, fifoReset}, 4'b0001);
  endtask

  task automatic bad_len(input int len);
    msgLen = 8'(len); req = 1'b1; tick(); req = 1'b0;
    check("badlen_pulse", {done, err, busy}, 4'b1010);
    tick();
    check("badlen_clear", {done, busy}, 2'b00);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; msgLen = 8'd0; padFinish = 1'b0; shaFinish = 1'b0;
    readPhase = 1'b0; writePhase = 1'b0; fifoEmpty = 1'b1; fifoFull = 1'b0;
    last_own = 2'd0; pad_seen = 1'b0;
    clear_obs();
    tick(); tick();
    check("reset_outputs", {busy, done, err, dataLen, padStart, shaStart, busOwner, chipSel,
                            wriEn, outEn, fifoReset, fifoWr, fifoRd}, 32'h4);
    check("reset_cycles", cycles, 0);
    check("addr_consts", {addrToBlock, addrToDigest}, {10'd0, 10'd64});
    rst = 1'b1; tick();

    run_hash(30, 40, 2, 32, 1'b0, 1'b0, 1'b0);

    pad_seen = 1'b0;
    bad_len(0);
    bad_len(56);
    bad_len($urandom_range(57, 255));
    check("badlen_no_pad", pad_seen, 0);

    run_hash(12, 3, 1, 32, 1'b1, 1'b0, 1'b0);

    run_hash(55, 5, 1, 34, 1'b0, 1'b1, 1'b1);

    for (int r = 0; r < 3; r++)
      run_hash($urandom_range(1, 55), $urandom_range(1, 40), $urandom_range(1, 4),
               $urandom_range(32, 40), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));

    msgLen = 8'd20; req = 1'b1; tick(); req = 1'b0;
    tick(); padFinish = 1'b1;
    for (int i = 0; i < 8 && !shaStart; i++) tick();
    padFinish = 1'b0; readPhase = 1'b1; tick();
    check("pre_reset_sha", {busOwner, shaStart}, 3'b101);
    rst = 1'b0; readPhase = 1'b0; tick();
    check("midrun_reset", {busy, done, err, dataLen, padStart, shaStart, busOwner, chipSel,
                           wriEn, outEn, fifoReset, fifoWr, fifoRd}, 32'h4);
    check("midrun_reset_cycles", cycles, 0);
    rst = 1'b1; tick();
    run_hash(7, 2, 1, 32, 1'b0, 1'b0, 1'b0);

    clear_obs();
    msgLen = 8'd10; req = 1'b1; tick(); req = 1'b0;
`ifdef HASH_SEQ_WDOG_EN
    for (int i = 0; i < 70000 && done_cnt == 0; i++) tick();
    check("wdog_done", done_cnt, 1);
    check("wdog_err", last_err, 3);
    check("wdog_cycles_sat", last_cycles, 16'hFFFF);
    check("wdog_outputs", {padStart, shaStart, fifoReset, busy}, 4'b0010);
`else
    for (int i = 0; i < 300; i++) tick();
    check("no_wdog_busy", {busy, padStart}, 2'b11);
    check("no_wdog_done", done_cnt, 0);
    rst = 1'b0; tick(); rst = 1'b1; tick();
`endif
    check("wr_out_exclusive", excl_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
